async_fifo_rd_unpacker: RTL
===========================

Name: async_fifo_rd_unpacker

Overview:
- Read-domain stage directly downstream of the async FIFO.
- Drains FIFO entries using the FIFO's rd_en/rd_empty/rd_data protocol, which has registered data one cycle after an accepted read.
- Re-presents each entry as RATIO = BITS/OUT_BITS narrower sub-words on a valid/ready stream.
- A 2-entry prefetch buffer with read-credit tracking hides the FIFO read latency, giving one sub-word per cycle sustained, including RATIO=1.

Parameters:
- BITS, 32, FIFO entry width; must be an integer multiple of OUT_BITS.
- OUT_BITS, 8, output sub-word width; RATIO = BITS/OUT_BITS, with RATIO >= 1.

Ports:
- rd_clk, input, 1, read-domain clock (the FIFO rd_clk).
- rd_rst, input, 1, synchronous active-high reset. The integration drives FIFO rd_rst_n = !rd_rst.
- fifo_rd_empty, input, 1, FIFO empty flag.
- fifo_rd_en, output, 1, FIFO read request.
- fifo_rd_data, input, BITS, FIFO read data; valid in the cycle after fifo_rd_en=1.
- m_valid, output, 1, sub-word available.
- m_ready, input, 1, downstream accepts the sub-word.
- m_data, output, OUT_BITS, current sub-word.
- m_last, output, 1, asserted with the final sub-word of an entry.

Behaviour:
- Reset:
  - count=0, inflight=0, idx=0, buffer pointers=0.
  - Outputs: m_valid=0, m_last=0, m_data=0, fifo_rd_en=0.
  - The outputs hold these values every cycle rd_rst=1.
- Derived signals:
  - pop = m_valid && m_ready && idx==RATIO-1.
  - fifo_rd_en = !rd_rst && !fifo_rd_empty && (count + inflight - pop) < 2. This is combinational, and it never asserts while the FIFO reports empty.
- inflight: register set to fifo_rd_en each cycle. When inflight=1, fifo_rd_data is written into the buffer at wptr at the end of that cycle; count increments and wptr toggles.
- Buffer: 2 entries with rptr/wptr, each 1 bit. count is 0..2 and never exceeds 2, which is guaranteed by the credit rule.
- Simultaneous capture and pop: count is unchanged, and both pointers advance.
- Output stream:
  - m_valid = (count != 0).
  - m_data = buffer[rptr] slice idx, LSB-first by default; idx=0 selects bits [OUT_BITS-1:0].
  - m_last = m_valid && idx==RATIO-1.
- idx counter (0..RATIO-1):
  - Increments on m_valid && m_ready.
  - Wraps to 0 on the handshake where idx==RATIO-1, which is also when pop occurs and rptr toggles.
  - For RATIO=1, idx is constant 0 and m_last = m_valid.
- Latency: fifo_rd_en in cycle N gives capture at end of N+1, so m_valid is first high in cycle N+2.
- Throughput: back-to-back FIFO reads are allowed. With m_ready held high, m_valid stays high continuously once primed, for any RATIO.
- Backpressure:
  - While m_valid && !m_ready, m_data, m_last and idx are held stable.
  - The buffer fills to 2, after which fifo_rd_en=0.
- Empty FIFO: no reads are issued. m_valid drops after the buffer drains; a bubble is legal.
- Reset mid-operation: an in-flight word, buffered words and partial sub-word progress are discarded. The FIFO pointer advance caused by the read is not undone.
- Protocol rule: fifo_rd_data is sampled only in the cycle where inflight=1 and ignored otherwise.

Optional Feature:
- Macro: ASYNC_FIFO_RD_UNPACKER_MSB_FIRST_EN.
- Defined: sub-word order is MSB-first; idx=0 selects bits [BITS-1:BITS-OUT_BITS]. m_last and handshake are unchanged.
- Undefined: LSB-first order as above.
- For RATIO=1 both builds are identical.

Test Plan:
1. Reset, then FIFO holds one entry 0xA1B2C3D4 with m_ready=1 -> fifo_rd_en pulses once; m_data = D4, C3, B2, A1 on 4 consecutive cycles; m_last=1 only with A1; m_valid=0 afterwards; fifo_rd_en=0 while empty.
2. MSB_FIRST_EN defined, same stimulus as scenario 1 -> m_data = A1, B2, C3, D4; m_last with D4.
3. OUT_BITS=32, FIFO preloaded with 8 entries 0..7, m_ready=1 -> 8 consecutive m_valid cycles, data 0..7 in order, m_last=1 every cycle, no bubble after the first word.
4. FIFO preloaded with 5 entries, m_ready=0 for 20 cycles -> exactly 2 fifo_rd_en pulses, then none; m_data and m_last stable. On release, all 20 sub-words are delivered in order with no loss or duplication.
5. Assert rd_rst for 1 cycle while idx=2 and count=2 -> next cycle m_valid=0, idx=0, count=0; subsequent entries restart at sub-word 0.
6. Random m_ready with 30% low, and a FIFO fed 200 random entries with random gaps -> scoreboard shows every entry reconstructed exactly once and in order, count never exceeds 2, and fifo_rd_en is never high when fifo_rd_empty=1.

Source files
------------

// File: rtl/async_fifo_rd_unpacker.sv
// async_fifo_rd_unpacker: drains a registered-read async FIFO into a 2-entry prefetch buffer and streams each entry as BITS/OUT_BITS sub-words.
// Define ASYNC_FIFO_RD_UNPACKER_MSB_FIRST_EN for MSB-first sub-word order (LSB-first otherwise).
module async_fifo_rd_unpacker #(
  parameter int BITS = 32,
  parameter int OUT_BITS = 8
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                fifo_rd_empty,
  output logic                fifo_rd_en,
  input  logic [BITS-1:0]     fifo_rd_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_BITS-1:0] m_data,
  output logic                m_last
);
  localparam int RATIO = BITS / OUT_BITS;
  localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam logic [IW-1:0] LAST = IW'(RATIO - 1);
  logic [BITS-1:0] buf_q [2];
  logic rptr, wptr, inflight, fire, pop, at_last;
  logic [1:0] count;
  logic [2:0] credit;
  logic [IW-1:0] idx, sel;
  logic [RATIO-1:0][OUT_BITS-1:0] words;
  // A read is issued only while buffered plus in-flight words (less this cycle's pop) leave a free slot.
  always_comb begin
    at_last = idx == LAST;
    m_valid = !rd_rst && count != 2'd0;
    fire = m_valid && m_ready;
    pop = fire && at_last;
    m_last = m_valid && at_last;
    credit = 3'(count) + 3'(inflight) - 3'(pop);
    fifo_rd_en = !rd_rst && !fifo_rd_empty && credit < 3'd2;
    words = buf_q[rptr];
`ifdef ASYNC_FIFO_RD_UNPACKER_MSB_FIRST_EN
    sel = LAST - idx;
`else
    sel = idx;
`endif
    m_data = m_valid ? words[sel] : '0;
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      count <= '0;
      inflight <= 1'b0;
      idx <= '0;
      rptr <= 1'b0;
      wptr <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      count <= count + 2'(inflight) - 2'(pop);
      if (inflight) wptr <= !wptr;
      if (pop) rptr <= !rptr;
      if (fire) idx <= at_last ? '0 : idx + 1'b1;
    end
  end
  // FIFO data is only meaningful the cycle after an accepted read.
  always_ff @(posedge rd_clk)
    if (!rd_rst && inflight) buf_q[wptr] <= fifo_rd_data;
endmodule
